// File: rtl/spiflash_arb_pkg.sv
// Shared types and constants for the W25Q32 flash arbiter: FSM states,
// OWNER encodings, default timing constants and a saturating increment.
package spiflash_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    OWN_A,
    OWN_B,
    ABORT_B,
    GUARD
  } arb_state_t;

  localparam logic [1:0] OWNER_NONE  = 2'b00;
  localparam logic [1:0] OWNER_A     = 2'b01;
  localparam logic [1:0] OWNER_B     = 2'b10;
  localparam logic [1:0] OWNER_GUARD = 2'b11;

  localparam int GUARD_CYCLES_DEF  = 3;
  localparam int ABORT_TIMEOUT_DEF = 64;

  // Counters stop at all-ones instead of wrapping back to zero.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/spiflash_arbiter_if.sv
// Bundle of the two masters' request/grant/pin signals and the shared flash
// pins. The arbiter uses the slave view; the masters and flash pads use the
// master view.
interface spiflash_arbiter_if;

  logic       a_req;
  logic       a_gnt;
  logic       a_ncs;
  logic       a_clk;
  logic       a_io0_o;
  logic       a_io0_oe;

  logic       b_req;
  logic       b_gnt;
  logic       b_abort;
  logic       b_ncs;
  logic       b_clk;
  logic       b_io0_o;
  logic       b_io0_oe;

  logic       nromcs;
  logic       romclk;
  logic       romio0_o;
  logic       romio0_oe;

  logic [1:0] owner;
  logic       forced;

  modport slave (
    input  a_req, a_ncs, a_clk, a_io0_o, a_io0_oe,
    input  b_req, b_ncs, b_clk, b_io0_o, b_io0_oe,
    output a_gnt, b_gnt, b_abort,
    output nromcs, romclk, romio0_o, romio0_oe,
    output owner, forced
  );

  modport master (
    output a_req, a_ncs, a_clk, a_io0_o, a_io0_oe,
    output b_req, b_ncs, b_clk, b_io0_o, b_io0_oe,
    input  a_gnt, b_gnt, b_abort,
    input  nromcs, romclk, romio0_o, romio0_oe,
    input  owner, forced
  );

endinterface

// File: rtl/spiflash_pinmux.sv
// Combinational flash pin selector. The registered arbiter state picks either
// master's pin drive straight through, or parks the bus (chip deselected,
// clock low, IO0 released) when nobody owns it.
module spiflash_pinmux
  import spiflash_arb_pkg::*;
(
  input  arb_state_t state,
  input  logic       a_ncs,
  input  logic       a_clk,
  input  logic       a_io0_o,
  input  logic       a_io0_oe,
  input  logic       b_ncs,
  input  logic       b_clk,
  input  logic       b_io0_o,
  input  logic       b_io0_oe,
  output logic       rom_ncs,
  output logic       rom_clk,
  output logic       rom_io0_o,
  output logic       rom_io0_oe
);

  // Owner pass-through with zero added latency; everything else parks.
  always_comb begin
    rom_ncs    = 1'b1;
    rom_clk    = 1'b0;
    rom_io0_o  = 1'b0;
    rom_io0_oe = 1'b0;
    case (state)
      OWN_A: begin
        rom_ncs    = a_ncs;
        rom_clk    = a_clk;
        rom_io0_o  = a_io0_o;
        rom_io0_oe = a_io0_oe;
      end
      OWN_B, ABORT_B: begin
        rom_ncs    = b_ncs;
        rom_clk    = b_clk;
        rom_io0_o  = b_io0_o;
        rom_io0_oe = b_io0_oe;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/spiflash_arbiter.sv
// Two-master arbiter for the shared serial flash. Port A (loader) has
// priority and is never preempted; port B is asked to abort and is forcibly
// released if it ignores the request. Every handover passes through a parked
// guard interval so the flash sees a minimum chip-select-high time.
module spiflash_arbiter
  import spiflash_arb_pkg::*;
#(
  parameter int GUARD_CYCLES  = GUARD_CYCLES_DEF,
  parameter int ABORT_TIMEOUT = ABORT_TIMEOUT_DEF
)
(
  input  logic                mclk,
  input  logic                rst,
  spiflash_arbiter_if.slave   bus
);

  // The last counter value seen inside a timed state, i.e. the state lasts
  // exactly N cycles before the edge that leaves it.
  localparam logic [7:0] GUARD_LAST = 8'(GUARD_CYCLES - 1);
  localparam logic [7:0] ABORT_LAST = 8'(ABORT_TIMEOUT - 1);

  arb_state_t state;
  logic [7:0] cnt;
  logic       a_rearm;
  logic       b_rearm;
  logic       a_gnt;
  logic       b_gnt;
  logic       b_abort;
  logic       forced;
  logic [1:0] owner;

  // Ownership FSM with its shared counter, re-arm flags and registered outputs.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      a_rearm <= 1'b1;
      b_rearm <= 1'b1;
      a_gnt   <= 1'b0;
      b_gnt   <= 1'b0;
      b_abort <= 1'b0;
      forced  <= 1'b0;
      owner   <= OWNER_NONE;
    end else begin
      forced <= 1'b0;
      cnt    <= sat_inc(cnt);
      if (!bus.a_req) a_rearm <= 1'b1;
      if (!bus.b_req) b_rearm <= 1'b1;
      case (state)
        IDLE: begin
          if (bus.a_req && a_rearm) begin
            state <= OWN_A;
            a_gnt <= 1'b1;
            owner <= OWNER_A;
            cnt   <= 8'd0;
          end else if (bus.b_req && b_rearm) begin
            state <= OWN_B;
            b_gnt <= 1'b1;
            owner <= OWNER_B;
            cnt   <= 8'd0;
          end
        end
        OWN_A: begin
          if (!bus.a_req) begin
            state <= GUARD;
            a_gnt <= 1'b0;
            owner <= OWNER_GUARD;
            cnt   <= 8'd0;
          end
        end
        OWN_B: begin
          if (!bus.b_req) begin
            state <= GUARD;
            b_gnt <= 1'b0;
            owner <= OWNER_GUARD;
            cnt   <= 8'd0;
          end else if (bus.a_req && a_rearm) begin
            state   <= ABORT_B;
            b_abort <= 1'b1;
            cnt     <= 8'd0;
          end
        end
        ABORT_B: begin
          if (!bus.b_req) begin
            state   <= GUARD;
            b_gnt   <= 1'b0;
            b_abort <= 1'b0;
            owner   <= OWNER_GUARD;
            cnt     <= 8'd0;
          end else if (cnt >= ABORT_LAST) begin
            state   <= GUARD;
            b_gnt   <= 1'b0;
            b_abort <= 1'b0;
            owner   <= OWNER_GUARD;
            cnt     <= 8'd0;
            forced  <= 1'b1;
            b_rearm <= 1'b0;
          end
        end
        GUARD: begin
          if (cnt >= GUARD_LAST) begin
            state <= IDLE;
            owner <= OWNER_NONE;
            cnt   <= 8'd0;
          end
        end
        default: begin
          state   <= IDLE;
          a_gnt   <= 1'b0;
          b_gnt   <= 1'b0;
          b_abort <= 1'b0;
          owner   <= OWNER_NONE;
          cnt     <= 8'd0;
        end
      endcase
    end
  end

  assign bus.a_gnt   = a_gnt;
  assign bus.b_gnt   = b_gnt;
  assign bus.b_abort = b_abort;
  assign bus.forced  = forced;
  assign bus.owner   = owner;

  spiflash_pinmux u_pinmux (
    .state      (state),
    .a_ncs      (bus.a_ncs),
    .a_clk      (bus.a_clk),
    .a_io0_o    (bus.a_io0_o),
    .a_io0_oe   (bus.a_io0_oe),
    .b_ncs      (bus.b_ncs),
    .b_clk      (bus.b_clk),
    .b_io0_o    (bus.b_io0_o),
    .b_io0_oe   (bus.b_io0_oe),
    .rom_ncs    (bus.nromcs),
    .rom_clk    (bus.romclk),
    .rom_io0_o  (bus.romio0_o),
    .rom_io0_oe (bus.romio0_oe)
  );

endmodule
